// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_pkg
//  Description : Shared RC4 definitions: key-scheduling state encoding,
//                S-box size and default key length, plus a helper that sizes
//                the key-byte index counter.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package rc4_pkg;

   localparam int S_SIZE             = 256;
   localparam int DEFAULT_KEY_LENGTH = 3;

   typedef enum logic [7:0] {
      IDLE   = 8'd0,
      INIT   = 8'd1,
      RD_SI  = 8'd2,
      CAP_SI = 8'd3,
      CAP_SJ = 8'd4,
      WR_SI  = 8'd5,
      WR_SJ  = 8'd6,
      DONE   = 8'd7
   } ksa_state_t;

   // Width of a counter indexing KEY_LENGTH bytes; never narrower than 1 bit.
   function automatic int kidx_width(input int key_length);
      return (key_length > 1) ? $clog2(key_length) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_byte_sel.sv
`default_nettype none
// ============================================================================
//  Module      : key_byte_sel
//  Description : Combinational selector returning byte kidx_i of the latched
//                key. Byte 0 is the most significant byte of key_i.
//  Ports       : key_i      - latched secret key, 8*KEY_LENGTH bits
//                kidx_i     - byte index, 0..KEY_LENGTH-1
//                key_byte_o - selected key byte
//  Revision    : 1.0 - initial release
// ============================================================================
module key_byte_sel
   import rc4_pkg::*;
#(
   parameter int KEY_LENGTH = DEFAULT_KEY_LENGTH,
   parameter int KIDX_W     = kidx_width(KEY_LENGTH)
) (
   input  logic [8*KEY_LENGTH-1:0] key_i,
   input  logic [KIDX_W-1:0]       kidx_i,
   output logic [7:0]              key_byte_o
);

   // Plain one-hot style mux; the index never exceeds KEY_LENGTH-1.
   always_comb begin
      key_byte_o = '0;
      for (int k = 0; k < KEY_LENGTH; k++) begin
         if (kidx_i == KIDX_W'(k)) begin
            key_byte_o = key_i[8*(KEY_LENGTH-k)-1 -: 8];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/key_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : key_scheduler
//  Description : RC4 key-scheduling algorithm driving an external S-RAM with
//                1-cycle read latency. Fills S[n]=n, then performs the 256
//                key-dependent swaps and pulses `finished` for one cycle.
//  Ports       : clk, reset     - clock, synchronous active-high reset
//                start          - level; a run begins on its rising edge
//                key            - secret key, byte 0 in the top byte
//                sOut           - S-RAM read data
//                sIn/sAddr/sWren- S-RAM write data, address, write enable
//                finished       - one-cycle completion pulse
//                iTap/jTap/stateTap - debug mirrors of i, j and state,
//                                 present only with KEY_SCHEDULER_TAPS_EN
//  Build macro : KEY_SCHEDULER_TAPS_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module key_scheduler
   import rc4_pkg::*;
#(
   parameter int RAM_WIDTH  = 8,
   parameter int RAM_LENGTH = 8,
   parameter int KEY_LENGTH = DEFAULT_KEY_LENGTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [8*KEY_LENGTH-1:0] key,
   input  logic [RAM_WIDTH-1:0]    sOut,
   output logic [RAM_WIDTH-1:0]    sIn,
   output logic [RAM_LENGTH-1:0]   sAddr,
   output logic                    sWren,
`ifdef KEY_SCHEDULER_TAPS_EN
   output logic                    finished,
   output logic [7:0]              iTap,
   output logic [7:0]              jTap,
   output logic [7:0]              stateTap
`else
   output logic                    finished
`endif
);

   localparam int         KIDX_W   = kidx_width(KEY_LENGTH);
   localparam logic [7:0] LAST_IDX = 8'(S_SIZE - 1);

   ksa_state_t              state_q;
   logic                    start_q;
   logic [7:0]              i_q, j_q, si_q, sj_q;
   logic [KIDX_W-1:0]       kidx_q;
   logic [8*KEY_LENGTH-1:0] key_q;
   logic                    sWren_q, finished_q;

   logic                    start_pulse_d;
   logic [7:0]              key_byte_d, si_d, j_d, i_d;
   logic [KIDX_W-1:0]       kidx_d;
   logic [7:0]              addr_d, data_d;

   key_byte_sel #(
      .KEY_LENGTH (KEY_LENGTH),
      .KIDX_W     (KIDX_W)
   ) u_key_byte_sel (
      .key_i      (key_q),
      .kidx_i     (kidx_q),
      .key_byte_o (key_byte_d)
   );

   assign start_pulse_d = start & ~start_q;
   assign si_d          = sOut[7:0];
   assign j_d           = j_q + si_d + key_byte_d;   // carries discarded
   assign i_d           = i_q + 8'd1;
   // Wrapping counter instead of i mod KEY_LENGTH.
   assign kidx_d        = (kidx_q == KIDX_W'(KEY_LENGTH - 1)) ? '0 : kidx_q + KIDX_W'(1);

   // Address/data must be combinational: in CAP_SI the address depends on
   // the read data arriving that same cycle.
   always_comb begin
      addr_d = 8'd0;
      data_d = 8'd0;
      case (state_q)
         INIT:    begin addr_d = i_q; data_d = i_q;  end
         RD_SI:   begin addr_d = i_q;                end
         CAP_SI:  begin addr_d = j_d;                end
         CAP_SJ:  begin addr_d = j_q;                end
         WR_SI:   begin addr_d = i_q; data_d = sj_q; end
         WR_SJ:   begin addr_d = j_q; data_d = si_q; end
         default: begin addr_d = 8'd0; data_d = 8'd0; end
      endcase
   end

   assign sAddr    = RAM_LENGTH'(addr_d);
   assign sIn      = RAM_WIDTH'(data_d);
   assign sWren    = sWren_q;
   assign finished = finished_q;

`ifdef KEY_SCHEDULER_TAPS_EN
   assign iTap     = i_q;
   assign jTap     = j_q;
   assign stateTap = state_q;
`endif

   // Write enable and finished are registered for the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         start_q    <= 1'b0;
         i_q        <= 8'd0;
         j_q        <= 8'd0;
         si_q       <= 8'd0;
         sj_q       <= 8'd0;
         kidx_q     <= '0;
         key_q      <= '0;
         sWren_q    <= 1'b0;
         finished_q <= 1'b0;
      end else begin
         start_q <= start;
         case (state_q)
            IDLE: begin
               if (start_pulse_d) begin
                  state_q <= INIT;
                  key_q   <= key;
                  i_q     <= 8'd0;
                  j_q     <= 8'd0;
                  kidx_q  <= '0;
                  sWren_q <= 1'b1;
               end
            end
            INIT: begin
               i_q <= i_d;
               if (i_q == LAST_IDX) begin
                  state_q <= RD_SI;
                  sWren_q <= 1'b0;
               end
            end
            RD_SI: begin
               state_q <= CAP_SI;
            end
            CAP_SI: begin
               si_q    <= si_d;
               j_q     <= j_d;
               state_q <= CAP_SJ;
            end
            CAP_SJ: begin
               sj_q    <= si_d;
               state_q <= WR_SI;
               sWren_q <= 1'b1;
            end
            WR_SI: begin
               state_q <= WR_SJ;
            end
            WR_SJ: begin
               sWren_q <= 1'b0;
               if (i_q == LAST_IDX) begin
                  state_q    <= DONE;
                  finished_q <= 1'b1;
               end else begin
                  i_q     <= i_d;
                  kidx_q  <= kidx_d;
                  state_q <= RD_SI;
               end
            end
            DONE: begin
               finished_q <= 1'b0;
               state_q    <= IDLE;
            end
            default: begin
               state_q    <= IDLE;
               sWren_q    <= 1'b0;
               finished_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/key_scheduler.md
KEY_SCHEDULER -- requirements
Module: key_scheduler

Interface
REQ-001 Parameters SHALL be: RAM_WIDTH, default 8, S-RAM data width; RAM_LENGTH, default 8, S-RAM address width; KEY_LENGTH, default 3, secret key length in bytes.
REQ-002 Reset SHALL be `reset`, synchronous, active-high; the clock SHALL be `clk`.
REQ-003 Ports SHALL be, in order (name, direction, width, meaning):
- `clk`, in, 1, clock.
- `reset`, in, 1, sync active-high reset.
- `start`, in, 1, level input; a run begins on its rising edge.
- `key`, in, 8*KEY_LENGTH, secret key; byte 0 = `key[8*KEY_LENGTH-1 -: 8]`.
- `sOut`, in, RAM_WIDTH, S-RAM read data.
- `sIn`, out, RAM_WIDTH, S-RAM write data.
- `sAddr`, out, RAM_LENGTH, S-RAM address.
- `sWren`, out, 1, S-RAM write enable.
- `finished`, out, 1, one-cycle completion pulse that starts the downstream decryptor.

Function
REQ-004 S-RAM read latency SHALL be 1 cycle: an address driven in cycle N has its data on `sOut` in cycle N+1.
REQ-005 Start detection SHALL be `start & ~start_q`, where `start_q` is `start` registered one cycle; the pulse SHALL be acted on only in IDLE, and SHALL be ignored in every other state.
REQ-006 On leaving IDLE, the block SHALL latch `key` internally; later changes to `key` SHALL NOT affect the run.
REQ-007 States SHALL be IDLE, INIT, RD_SI, CAP_SI, CAP_SJ, WR_SI, WR_SJ, DONE.
REQ-008 IDLE: `sWren`=0, `sAddr`=0, `sIn`=0; on a start pulse go to INIT, with i=0, j=0, key index kidx=0.
REQ-009 INIT: drive `sAddr`=i, `sIn`=i, `sWren`=1, then increment i; after the write with i=255, i SHALL wrap to 0 and the state SHALL go to RD_SI.
REQ-010 RD_SI: drive `sAddr`=i, `sWren`=0.
REQ-011 CAP_SI: latch si=`sOut`; compute j_next=(j+si+key_byte[kidx]) mod 256; register j=j_next; drive `sAddr`=j_next.
REQ-012 CAP_SJ: latch sj=`sOut`.
REQ-013 WR_SI: drive `sAddr`=i, `sIn`=sj, `sWren`=1.
REQ-014 WR_SJ: drive `sAddr`=j, `sIn`=si, `sWren`=1.
- If i=255, go to DONE.
- Otherwise increment i, set kidx = (kidx==KEY_LENGTH-1) ? 0 : kidx+1, and go to RD_SI.
REQ-015 kidx SHALL be a wrapping counter; no divider or modulo operator SHALL be synthesised.
REQ-016 The i==j case SHALL perform both writes unchanged; the net effect is S[i] unchanged.
REQ-017 All index arithmetic SHALL be 8-bit modulo 256, with carries discarded.
REQ-018 DONE: `finished`=1 for exactly one cycle, `sWren`=0, then go to IDLE.
REQ-019 Latency SHALL be: a start edge sampled at clock edge 0 gives 256 INIT cycles plus 1280 swap cycles, with `finished` high during cycle 1537.
REQ-020 `sWren` SHALL be high only in INIT, WR_SI and WR_SJ.

Reset
REQ-021 Reset SHALL apply at any point, including mid-run, and SHALL force:
- state = IDLE;
- i, j, kidx, si, sj, latched key, `start_q` = 0;
- `sWren` = 0, `finished` = 0 from the next cycle.
REQ-022 Reset SHALL NOT restore S-RAM contents; a new start SHALL re-run INIT fully.

Configuration
REQ-023 Macro KEY_SCHEDULER_TAPS_EN, when defined, SHALL add output ports `iTap`[7:0], `jTap`[7:0] and `stateTap`[7:0], mirroring i, j and the state encoding.
REQ-024 Without KEY_SCHEDULER_TAPS_EN, those ports SHALL be absent and the function SHALL be identical.

Structure
REQ-025 A shared package `rc4_pkg` SHALL hold the state enum `ksa_state_t` (8-bit encoding) and the constants S_SIZE=256 and DEFAULT_KEY_LENGTH=3.
REQ-026 One sub-module, `key_byte_sel`, SHALL be combinational and return key byte kidx from the latched key.
REQ-027 Edge detection and the FSM SHALL reside in key_scheduler.

Verification
REQ-028 Bench scenarios, each stimulus -> required response:
- INIT: any start -> 256 consecutive writes (`sAddr`=n, `sIn`=n, n=0..255).
- Key 0x000000, behavioural S-RAM:
  - iteration 0 -> writes S[0]=0 then S[0]=0;
  - iteration 2 -> j=3, S[2]=3, S[3]=2.
- Key 0x010203 -> iteration 0: j=1, WR_SI writes addr 0 data 1, WR_SJ writes addr 1 data 0.
- Key 0x00033C -> final 256-byte S matches the software RC4 KSA model; `finished` high exactly at cycle 1537, width 1.
- Disturbances:
  - start re-pulsed mid-run -> ignored, completion timing unchanged;
  - `key` changed mid-run -> no effect on result.
- Reset asserted in the 500th cycle -> IDLE and `sWren`=0 next cycle; a new start gives a correct full result.
